// File: rtl/serial_exe_unit_pkg.sv
// rtl/serial_exe_unit_pkg.sv - shared typedefs for serial_exe_unit (ALU op codes, FSM states)
package serial_exe_unit_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_SLTU = 3'd6,
    OP_PASS = 3'd7
  } exe_alu_op_e;

  typedef enum logic [1:0] {
    ST_LO = 2'd0,
    ST_HI = 2'd1,
    ST_WB = 2'd2
  } exe_state_e;

  // Ops that run the adder as a subtract and therefore inject cin=1 on the low beat.
  function automatic logic is_sub_op(input exe_alu_op_e op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

endpackage

// File: rtl/serial_exe_unit_if.sv
// rtl/serial_exe_unit_if.sv - decode beat stream, register-file write port and hazard report bundle
interface serial_exe_unit_if;

  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [2:0]  op_i;
  logic [15:0] a_half_i;
  logic [15:0] b_half_i;
  logic [4:0]  rd_i;
  logic        rf_write_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        busy_o;
  logic [4:0]  busy_rd_o;

  modport master (
    output valid_i, flush_i, op_i, a_half_i, b_half_i, rd_i, rf_write_i,
    input  ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, busy_rd_o
  );

  modport slave (
    input  valid_i, flush_i, op_i, a_half_i, b_half_i, rd_i, rf_write_i,
    output ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, busy_rd_o
  );

endinterface

// File: rtl/serial_exe_unit_alu16_slice.sv
// rtl/serial_exe_unit_alu16_slice.sv - combinational 16-bit ALU slice with carry chain
// N/V flags exist only when SERIAL_EXE_SLT_EN is defined.
module alu16_slice
  import serial_exe_unit_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  exe_alu_op_e op,
  input  logic        cin,
  output logic [15:0] y,
  output logic        cout,
  output logic        n,
  output logic        v
);

  logic [15:0] b_eff;
  logic [16:0] sum;

  always_comb begin
    b_eff = is_sub_op(op) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {16'b0, cin};
    cout  = sum[16];
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_PASS: y = a;
      default: y = sum[15:0];
    endcase
`ifdef SERIAL_EXE_SLT_EN
    n = sum[15];
    v = (a[15] == b_eff[15]) && (sum[15] != a[15]);
`else
    n = 1'b0;
    v = 1'b0;
`endif
  end

endmodule

// File: rtl/serial_exe_unit.sv
// rtl/serial_exe_unit.sv - two-beat serial execute stage feeding the register-file write port
// Define SERIAL_EXE_SLT_EN to enable SLT/SLTU compare results; otherwise they write zero.
module serial_exe_unit
  import serial_exe_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  serial_exe_unit_if.slave bus
);

  localparam logic [1:0] S_LO = ST_LO;
  localparam logic [1:0] S_HI = ST_HI;
  localparam logic [1:0] S_WB = ST_WB;

  logic [1:0]  state_q, state_d;
  logic        carry_q, carry_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] lo_q, lo_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ready, accept;
  exe_alu_op_e alu_op;
  logic        alu_cin;
  logic [15:0] alu_y;
  logic        alu_cout, alu_n, alu_v;
  logic [31:0] hi_result;

  alu16_slice u_slice (
    .a    (bus.a_half_i),
    .b    (bus.b_half_i),
    .op   (alu_op),
    .cin  (alu_cin),
    .y    (alu_y),
    .cout (alu_cout),
    .n    (alu_n),
    .v    (alu_v)
  );

`ifndef SERIAL_EXE_SLT_EN
  logic unused_flags;
  assign unused_flags = alu_n ^ alu_v;
`endif

  always_comb begin
    ready   = (state_q != S_WB) && !rst;
    accept  = bus.valid_i && ready;
    // The single slice is shared: low beat sees the incoming op, high beat the latched one.
    alu_op  = (state_q == S_LO) ? exe_alu_op_e'(bus.op_i) : exe_alu_op_e'(op_q);
    alu_cin = (state_q == S_LO) ? is_sub_op(exe_alu_op_e'(bus.op_i)) : carry_q;
    case (exe_alu_op_e'(op_q))
`ifdef SERIAL_EXE_SLT_EN
      OP_SLT:  hi_result = {31'b0, alu_n ^ alu_v};
      OP_SLTU: hi_result = {31'b0, !alu_cout};
`else
      OP_SLT, OP_SLTU: hi_result = 32'h0;
`endif
      default: hi_result = {alu_y, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    op_d    = op_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    lo_d    = lo_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (bus.flush_i) begin
      state_d = S_LO;
    end else begin
      case (state_q)
        S_LO: if (accept) begin
          state_d = S_HI;
          op_d    = bus.op_i;
          rd_d    = bus.rd_i;
          wr_d    = bus.rf_write_i;
          lo_d    = alu_y;
          carry_d = alu_cout;
        end
        S_HI: if (accept) begin
          state_d = S_WB;
          carry_d = alu_cout;
          waddr_d = rd_q;
          wdata_d = hi_result;
        end
        default: state_d = S_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LO;
      carry_q <= 1'b0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      wr_q    <= 1'b0;
      lo_q    <= 16'd0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // A flush coincident with WB kills the strobe in the same cycle.
  assign bus.ready_o    = ready;
  assign bus.rf_we_o    = (state_q == S_WB) && wr_q && !bus.flush_i && !rst;
  assign bus.rf_waddr_o = waddr_q;
  assign bus.rf_wdata_o = wdata_q;
  assign bus.busy_o     = (state_q != S_LO);
  assign bus.busy_rd_o  = (state_q != S_LO) ? rd_q : 5'd0;

endmodule

// File: tb/tb_serial_exe_unit.sv
// tb/tb_serial_exe_unit.sv - self-checking bench for serial_exe_unit
module tb_serial_exe_unit;
  import serial_exe_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_exe_unit_if bus ();

  serial_exe_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef SERIAL_EXE_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (SLT_EN && ($signed(a) < $signed(b))) ? 32'd1 : 32'd0;
      3'd6: return (SLT_EN && (a < b)) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.valid_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.a_half_i   = 16'($urandom);
    bus.b_half_i   = 16'($urandom);
  endtask

  task automatic run_instr(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic wr,
                           input int gap, input logic [31:0] exp);
    chk({tag, ".ready_lo"}, 32'(bus.ready_o), 32'd1);
    bus.valid_i    = 1'b1;
    bus.op_i       = op;
    bus.a_half_i   = a[15:0];
    bus.b_half_i   = b[15:0];
    bus.rd_i       = rd;
    bus.rf_write_i = wr;
    step();
    bus.op_i       = 3'($urandom);
    bus.rd_i       = 5'($urandom);
    bus.rf_write_i = 1'($urandom);
    for (int g = 0; g <= gap; g++) begin
      if (g < gap) idle_inputs();
      chk({tag, ".busy"}, 32'(bus.busy_o), 32'd1);
      chk({tag, ".busy_rd"}, 32'(bus.busy_rd_o), 32'(rd));
      chk({tag, ".we_early"}, 32'(bus.rf_we_o), 32'd0);
      if (g < gap) step();
    end
    bus.valid_i  = 1'b1;
    bus.a_half_i = a[31:16];
    bus.b_half_i = b[31:16];
    step();
    idle_inputs();
    chk({tag, ".we"}, 32'(bus.rf_we_o), 32'(wr));
    chk({tag, ".waddr"}, 32'(bus.rf_waddr_o), 32'(rd));
    chk({tag, ".wdata"}, bus.rf_wdata_o, exp);
    chk({tag, ".ready_wb"}, 32'(bus.ready_o), 32'd0);
    chk({tag, ".busy_wb"}, 32'(bus.busy_o), 32'd1);
    step();
    chk({tag, ".we_after"}, 32'(bus.rf_we_o), 32'd0);
    chk({tag, ".ready_after"}, 32'(bus.ready_o), 32'd1);
    chk({tag, ".busy_after"}, 32'(bus.busy_o), 32'd0);
    chk({tag, ".busy_rd_after"}, 32'(bus.busy_rd_o), 32'd0);
    chk({tag, ".wdata_hold"}, bus.rf_wdata_o, exp);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{3'(OP_ADD),  32'h0001_FFFF, 32'h0000_0001, 5'd5,  1'b1, 0, 32'h0002_0000};
    vecs[1]  = '{3'(OP_SUB),  32'h0000_0000, 32'h0000_0001, 5'd9,  1'b1, 3, 32'hFFFF_FFFF};
    vecs[2]  = '{3'(OP_SLT),  32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 1'b1, 0, SLT_EN ? 32'h1 : 32'h0};
    vecs[3]  = '{3'(OP_SLTU), 32'hFFFF_FFFF, 32'h0000_0001, 5'd11, 1'b1, 1, 32'h0};
    vecs[4]  = '{3'(OP_SLT),  32'h0000_0001, 32'hFFFF_FFFF, 5'd12, 1'b1, 0, 32'h0};
    vecs[5]  = '{3'(OP_SLTU), 32'h0000_0001, 32'hFFFF_FFFF, 5'd13, 1'b1, 0, SLT_EN ? 32'h1 : 32'h0};
    vecs[6]  = '{3'(OP_XOR),  32'hF0F0_F0F0, 32'hFFFF_0000, 5'd14, 1'b0, 0, 32'h0F0F_F0F0};
    vecs[7]  = '{3'(OP_AND),  32'hFF00_FF00, 32'h0F0F_0F0F, 5'd15, 1'b1, 2, 32'h0F00_0F00};
    vecs[8]  = '{3'(OP_OR),   32'hFF00_FF00, 32'h0F0F_0F0F, 5'd16, 1'b1, 0, 32'hFF0F_FF0F};
    vecs[9]  = '{3'(OP_SUB),  32'h0001_0000, 32'h0000_0001, 5'd17, 1'b1, 1, 32'h0000_FFFF};
    vecs[10] = '{3'(OP_PASS), 32'hCAFE_BABE, 32'h1234_0000, 5'd31, 1'b1, 0, 32'hCAFE_BABE};
    vecs[11] = '{3'(OP_SLT),  32'h8000_0000, 32'h7FFF_FFFF, 5'd1,  1'b1, 0, SLT_EN ? 32'h1 : 32'h0};

    rst            = 1'b1;
    bus.op_i       = 3'd0;
    bus.rd_i       = 5'd0;
    bus.rf_write_i = 1'b0;
    idle_inputs();
    step();
    step();
    chk("reset.ready", 32'(bus.ready_o), 32'd0);
    chk("reset.we", 32'(bus.rf_we_o), 32'd0);
    chk("reset.waddr", 32'(bus.rf_waddr_o), 32'd0);
    chk("reset.wdata", bus.rf_wdata_o, 32'd0);
    chk("reset.busy", 32'(bus.busy_o), 32'd0);
    chk("reset.busy_rd", 32'(bus.busy_rd_o), 32'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 12; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                vecs[i].wr, vecs[i].gap, vecs[i].exp);

    // Flush while in HI, with a coincident high beat: no write, clean restart.
    bus.valid_i = 1'b1; bus.op_i = 3'(OP_ADD); bus.rd_i = 5'd7; bus.rf_write_i = 1'b1;
    bus.a_half_i = 16'hFFFF; bus.b_half_i = 16'hFFFF;
    step();
    bus.flush_i = 1'b1; bus.a_half_i = 16'h0001; bus.b_half_i = 16'h0001;
    step();
    idle_inputs();
    chk("flush_hi.busy", 32'(bus.busy_o), 32'd0);
    chk("flush_hi.busy_rd", 32'(bus.busy_rd_o), 32'd0);
    chk("flush_hi.we", 32'(bus.rf_we_o), 32'd0);
    chk("flush_hi.ready", 32'(bus.ready_o), 32'd1);
    step();
    chk("flush_hi.we2", 32'(bus.rf_we_o), 32'd0);
    run_instr("after_flush", 3'(OP_ADD), 32'd2, 32'd3, 5'd8, 1'b1, 0, 32'h0000_0005);

    // Flush at LO with valid: beat dropped.
    bus.valid_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 3'(OP_ADD); bus.rd_i = 5'd20;
    step();
    idle_inputs();
    chk("flush_lo.busy", 32'(bus.busy_o), 32'd0);

    // Flush coincident with WB: strobe suppressed combinationally.
    bus.valid_i = 1'b1; bus.op_i = 3'(OP_ADD); bus.rd_i = 5'd21; bus.rf_write_i = 1'b1;
    bus.a_half_i = 16'd1; bus.b_half_i = 16'd1;
    step();
    bus.a_half_i = 16'd0; bus.b_half_i = 16'd0;
    step();
    bus.valid_i = 1'b0;
    chk("flush_wb.we_pre", 32'(bus.rf_we_o), 32'd1);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_wb.we", 32'(bus.rf_we_o), 32'd0);
    step();
    idle_inputs();
    chk("flush_wb.busy", 32'(bus.busy_o), 32'd0);
    chk("flush_wb.we_after", 32'(bus.rf_we_o), 32'd0);

    // Reset during HI discards the instruction.
    bus.valid_i = 1'b1; bus.op_i = 3'(OP_ADD); bus.rd_i = 5'd22; bus.rf_write_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_hi.we", 32'(bus.rf_we_o), 32'd0);
    chk("rst_hi.waddr", 32'(bus.rf_waddr_o), 32'd0);
    chk("rst_hi.wdata", bus.rf_wdata_o, 32'd0);
    chk("rst_hi.busy", 32'(bus.busy_o), 32'd0);
    chk("rst_hi.busy_rd", 32'(bus.busy_rd_o), 32'd0);
    chk("rst_hi.ready", 32'(bus.ready_o), 32'd0);
    rst = 1'b0;
    #1;
    run_instr("after_rst", 3'(OP_PASS), 32'h1234_5678, 32'hDEAD_BEEF, 5'd4, 1'b1, 0, 32'h1234_5678);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      if ($urandom_range(0, 3) == 0) r_a = {r_a[31:16], 16'hFFFF};
      if ($urandom_range(0, 3) == 0) r_b = r_a;
      run_instr($sformatf("rnd%0d", i), r_op, r_a, r_b, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), ref_model(r_op, r_a, r_b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_exe_unit.md
# serial_exe_unit

Execute-stage consumer of the decode unit's 16-bit serialized operand stream. It accepts each instruction as two half-word beats, low half first, and runs a 16-bit ALU slice twice with a carried carry/borrow. It reassembles the 32-bit result and issues a single-cycle register-file write. It sits between decode (operand serializer) and the register-file write port, and reports its in-flight destination so decode can detect hazards.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- valid_i  in  1  decode presents a beat
- ready_o  out  1  beat accepted when valid_i && ready_o
- flush_i  in  1  abandon any partial instruction (branch/jump redirect)
- op_i  in  3  exe_alu_op_e, sampled on low beat only
- a_half_i  in  16  operand A half (decode serializer output)
- b_half_i  in  16  operand B half (register-file rs2 half)
- rd_i  in  5  destination, sampled on low beat
- rf_write_i  in  1  write enable request, sampled on low beat
- rf_we_o  out  1  register-file write strobe
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- busy_o  out  1  instruction in flight (low beat taken, write not yet issued)
- busy_rd_o  out  5  rd of in-flight instruction

## Operation
- States: LO (await low beat), HI (await high beat), WB (issue write).
- LO: on accept, latch op, rd, rf_write. Compute the low result with the slice (cin=1 for SUB/SLT/SLTU, else 0). Store result[15:0] and carry-out → HI.
- HI: on accept, compute the high result with cin = stored carry → WB.
- WB: rf_we_o = latched rf_write; rf_waddr_o = rd; rf_wdata_o = assembled result → LO.
- Ops: ADD a+b; SUB a+~b+1; AND; OR; XOR; PASS = a (b ignored); SLT/SLTU.
- SLT: {31'b0, N^V} from the high-half subtract. SLTU: {31'b0, !cout_hi}. Low result is discarded for these ops.
- Logic ops ignore carry; the carry register still updates (don't-care).
- rf_write_i=0: the sequence still runs; WB completes with rf_we_o=0.
- flush_i: state → LO and busy_o → 0 next cycle. No write is issued. flush_i beats a coincident valid_i (beat dropped, ready_o irrelevant). Flush in WB cancels the write only if asserted in the same cycle: rf_we_o is gated by !flush_i combinationally.

## Timing
- ready_o = (state != WB) && !rst, combinational.
- Arbitrary gaps between beats are allowed. State, carry and the partial result hold while valid_i=0.
- Latency: rf_we_o is high exactly one cycle, the cycle after the high beat is accepted. Minimum three cycles per instruction. The next low beat is accepted the cycle after WB.
- busy_o rises the cycle after the low beat is accepted and falls the cycle after WB (i.e., high during HI and WB). busy_rd_o holds rd while busy_o=1, else 0.
- Reset: state LO. rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0, busy_rd_o=0, carry=0. ready_o=0 while rst=1. Reset mid-instruction discards it without a write.
- rf_waddr_o and rf_wdata_o are registered and hold their last values outside WB.

## Configuration
- SERIAL_EXE_SLT_EN defined: SLT/SLTU behave as above.
- Undefined: the N/V/compare logic is removed. SLT/SLTU produce result 0x0000_0000, with the write still issued per rf_write.

## Structure
- typedefs package: exe_alu_op_e (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, PASS=7) and exe_state_e (LO, HI, WB).
- Sub-module alu16_slice: combinational. Inputs a, b, op, cin; outputs y[15:0], cout, n, v. Instantiated once and time-shared across both beats.

## Test plan
- ADD a=0x0001_FFFF, b=0x0000_0001, rd=5, back-to-back beats → single rf_we_o pulse one cycle after the high beat, waddr=5, wdata=0x0002_0000.
- SUB a=0x0000_0000, b=0x0000_0001 with 3 idle cycles between beats → wdata=0xFFFF_FFFF. Carry is held across the gap; busy_o=1, busy_rd_o=rd throughout.
- SLT a=0xFFFF_FFFF, b=0x0000_0001 → 0x0000_0001. SLTU with the same operands → 0x0000_0000. With SERIAL_EXE_SLT_EN undefined, both → 0x0000_0000.
- flush_i with valid_i after the low beat (ADD, rd=7) → no rf_we_o. The following ADD 2+3, rd=8, writes 0x0000_0005 to 8, proving the carry and state are clean.
- rf_write_i=0, XOR 0xF0F0_F0F0 ^ 0xFFFF_0000 → rf_we_o stays 0. ready_o drops for exactly the WB cycle.
- rst asserted during HI → all outputs zero next cycle, no write. After release, PASS a=0x1234_5678 → wdata=0x1234_5678.
